// File: rtl/clock_pkg.sv
// Shared types and constants for the clock core: FSM states, time limits
// and the set_mode output encoding.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        RING   = 3'd3,
        SNOOZE = 3'd4
    } state_t;

    localparam int HOUR_MAX    = 23;
    localparam int MIN_MAX     = 59;
    localparam int SEC_PER_MIN = 60;

    localparam logic [1:0] SM_NONE = 2'd0;
    localparam logic [1:0] SM_HOUR = 2'd1;
    localparam logic [1:0] SM_MIN  = 2'd2;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            SET_H:   mode_of = SM_HOUR;
            SET_M:   mode_of = SM_MIN;
            default: mode_of = SM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wrap_inc.sv
// Modulo incrementer: value+1 when enabled, wrapping MAX back to 0.
module wrap_inc #(
    parameter int WIDTH = 5,
    parameter int MAX   = 23
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] value_nxt
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    always_comb begin
        value_nxt = value;
        if (en) begin
            value_nxt = (value == TOP) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm time entry, arm state, match detection and the
// ring / snooze / auto-timeout sequence.
//
//   state  | meaning
//   IDLE   | waiting; trigger starts ringing, btn_set enters hour entry
//   SET_H  | btn_up advances alarm hour
//   SET_M  | btn_up advances alarm minute
//   RING   | buzzer on, counting ring seconds toward timeout
//   SNOOZE | buzzer off, snooze seconds counting down to re-ring
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] set_mode
);

    localparam int RS_W = $clog2(RING_TIMEOUT_S + 1);
    localparam int SS_W = $clog2(SNOOZE_MIN * SEC_PER_MIN + 1);
    localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [RS_W-1:0] RING_LAST   = RS_W'(RING_TIMEOUT_S - 1);
    localparam logic [SS_W-1:0] SNOOZE_LOAD = SS_W'(SNOOZE_MIN * SEC_PER_MIN);
    localparam logic [SS_W-1:0] SNOOZE_TC   = SS_W'(1);
    localparam logic [SC_W-1:0] SC_MAX      = SC_W'(MAX_SNOOZE);

    state_t          state, state_nxt;
    logic            armed_nxt;
    logic            match, match_q, trigger;
    logic [4:0]      hour_nxt;
    logic [5:0]      min_nxt;
    logic [RS_W-1:0] ring_sec, ring_sec_nxt;
    logic [SS_W-1:0] snooze_sec, snooze_sec_nxt;
    logic [SC_W-1:0] snooze_cnt, snooze_cnt_nxt;

    assign match   = armed && (hour == alarm_hour) && (minute == alarm_min);
    assign trigger = match && !match_q;

    wrap_inc #(.WIDTH(5), .MAX(HOUR_MAX)) u_hour_inc (
        .value     (alarm_hour),
        .en        ((state == SET_H) && btn_up),
        .value_nxt (hour_nxt)
    );

    wrap_inc #(.WIDTH(6), .MAX(MIN_MAX)) u_min_inc (
        .value     (alarm_min),
        .en        ((state == SET_M) && btn_up),
        .value_nxt (min_nxt)
    );

    always_comb begin
        state_nxt      = state;
        armed_nxt      = armed;
        ring_sec_nxt   = ring_sec;
        snooze_sec_nxt = snooze_sec;
        snooze_cnt_nxt = snooze_cnt;
        case (state)
            IDLE: begin
                if (btn_arm) armed_nxt = !armed;
                if (trigger) begin
                    state_nxt      = RING;
                    ring_sec_nxt   = '0;
                    snooze_cnt_nxt = '0;
                end else if (btn_set) begin
                    state_nxt = SET_H;
                end
            end
            SET_H: begin
                if (btn_arm) armed_nxt = !armed;
                if (btn_set) state_nxt = SET_M;
            end
            SET_M: begin
                if (btn_arm) armed_nxt = !armed;
                if (btn_set) state_nxt = IDLE;
            end
            RING: begin
                if (tick_1hz) ring_sec_nxt = ring_sec + 1'b1;
                if (btn_arm) begin
                    armed_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (btn_snooze && (snooze_cnt < SC_MAX)) begin
                    snooze_cnt_nxt = snooze_cnt + 1'b1;
                    snooze_sec_nxt = SNOOZE_LOAD;
                    state_nxt      = SNOOZE;
                end else if (tick_1hz && (ring_sec == RING_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            SNOOZE: begin
                if (btn_arm) begin
                    armed_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (tick_1hz) begin
                    if (snooze_sec == SNOOZE_TC) begin
                        state_nxt    = RING;
                        ring_sec_nxt = '0;
                    end else begin
                        snooze_sec_nxt = snooze_sec - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            ring_sec   <= '0;
            snooze_sec <= '0;
            snooze_cnt <= '0;
            match_q    <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            set_mode   <= SM_NONE;
        end else begin
            state      <= state_nxt;
            armed      <= armed_nxt;
            alarm_hour <= hour_nxt;
            alarm_min  <= min_nxt;
            ring_sec   <= ring_sec_nxt;
            snooze_sec <= snooze_sec_nxt;
            snooze_cnt <= snooze_cnt_nxt;
            match_q    <= match;
            ringing    <= (state_nxt == RING);
            snoozing   <= (state_nxt == SNOOZE);
            set_mode   <= mode_of(state_nxt);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: table of set-mode vectors plus hand-written
// ring / snooze / reset sequences.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [4:0] hour;
    logic [5:0] minute;
    logic       btn_set, btn_up, btn_arm, btn_snooze;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       armed, ringing, snoozing;
    logic [1:0] set_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .SNOOZE_MIN     (1),
        .RING_TIMEOUT_S (5),
        .MAX_SNOOZE     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .hour       (hour),
        .minute     (minute),
        .btn_set    (btn_set),
        .btn_up     (btn_up),
        .btn_arm    (btn_arm),
        .btn_snooze (btn_snooze),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .armed      (armed),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .set_mode   (set_mode)
    );

    typedef struct {
        logic       set;
        logic       up;
        logic       arm;
        logic [4:0] eh;
        logic [5:0] em;
        logic       ea;
        logic [1:0] emode;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic set, input logic up, input logic arm,
                                input int eh, input int em, input logic ea, input int emode);
        vec_t v;
        v.set   = set;
        v.up    = up;
        v.arm   = arm;
        v.eh    = 5'(eh);
        v.em    = 6'(em);
        v.ea    = ea;
        v.emode = 2'(emode);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle with the given pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic set, input logic up, input logic arm,
                       input logic snz, input logic tk);
        btn_set    = set;
        btn_up     = up;
        btn_arm    = arm;
        btn_snooze = snz;
        tick_1hz   = tk;
        @(posedge clk);
        #1;
        btn_set    = 1'b0;
        btn_up     = 1'b0;
        btn_arm    = 1'b0;
        btn_snooze = 1'b0;
        tick_1hz   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (9) cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0;
        btn_set = 1'b0; btn_up = 1'b0; btn_arm = 1'b0; btn_snooze = 1'b0;
        hour = 5'd12; minute = 6'd0;

        // Set-mode vectors: {set, up, arm, exp_hour, exp_min, exp_armed, exp_mode}
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        for (int i = 1; i <= 7; i++) vecs.push_back(mk(0, 1, 0, i, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 7, 0, 0, 2));
        for (int i = 1; i <= 30; i++) vecs.push_back(mk(0, 1, 0, 7, i, 0, 2));
        vecs.push_back(mk(1, 0, 0, 7, 30, 0, 0));
        vecs.push_back(mk(0, 1, 0, 7, 30, 0, 0));
        vecs.push_back(mk(1, 0, 0, 7, 30, 0, 1));
        for (int i = 8; i <= 23; i++) vecs.push_back(mk(0, 1, 0, i, 30, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 30, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 30, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 30, 0, 1));
        for (int i = 1; i <= 7; i++) vecs.push_back(mk(0, 1, 0, i, 30, 0, 1));
        vecs.push_back(mk(1, 0, 0, 7, 30, 0, 2));
        for (int i = 31; i <= 59; i++) vecs.push_back(mk(0, 1, 0, 7, i, 0, 2));
        vecs.push_back(mk(0, 1, 0, 7, 0, 0, 2));
        for (int i = 1; i <= 29; i++) vecs.push_back(mk(0, 1, 0, 7, i, 0, 2));
        vecs.push_back(mk(1, 1, 0, 7, 30, 0, 0));

        #23;
        chk("rst_alarm_hour", alarm_hour, 0);
        chk("rst_alarm_min", alarm_min, 0);
        chk("rst_armed", armed, 0);
        chk("rst_ringing", ringing, 0);
        chk("rst_snoozing", snoozing, 0);
        chk("rst_set_mode", set_mode, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].set, vecs[i].up, vecs[i].arm, 0, 0);
            chk($sformatf("vec%0d_hour", i), alarm_hour, vecs[i].eh);
            chk($sformatf("vec%0d_min", i), alarm_min, vecs[i].em);
            chk($sformatf("vec%0d_armed", i), armed, vecs[i].ea);
            chk($sformatf("vec%0d_mode", i), set_mode, vecs[i].emode);
            chk($sformatf("vec%0d_ring", i), ringing, 0);
        end

        // Arm, then time reaches 07:30
        hour = 5'd7; minute = 6'd29;
        cyc(0, 0, 1, 0, 0);
        chk("arm_on", armed, 1);
        cyc(0, 0, 0, 0, 0);
        chk("no_ring_0729", ringing, 0);
        minute = 6'd30;
        cyc(0, 0, 0, 0, 0);
        chk("ring_on_match", ringing, 1);
        ticks(4);
        chk("ring_after_4_ticks", ringing, 1);
        ticks(1);
        chk("timeout_ring_off", ringing, 0);
        chk("timeout_armed_kept", armed, 1);
        repeat (30) cyc(0, 0, 0, 0, 0);
        chk("no_retrigger", ringing, 0);

        // Snooze twice, third press ignored, then timeout
        minute = 6'd31; cyc(0, 0, 0, 0, 0);
        minute = 6'd30; cyc(0, 0, 0, 0, 0);
        chk("retrigger", ringing, 1);
        cyc(0, 0, 0, 1, 0);
        chk("snz1_snoozing", snoozing, 1);
        chk("snz1_ring_off", ringing, 0);
        ticks(59);
        chk("snz1_59_ticks", snoozing, 1);
        ticks(1);
        chk("snz1_reringing", ringing, 1);
        chk("snz1_done", snoozing, 0);
        cyc(0, 0, 0, 1, 0);
        chk("snz2_snoozing", snoozing, 1);
        ticks(60);
        chk("snz2_reringing", ringing, 1);
        cyc(0, 0, 0, 1, 0);
        chk("snz3_ignored_ring", ringing, 1);
        chk("snz3_ignored_snz", snoozing, 0);
        ticks(4);
        chk("max_snz_ring_4", ringing, 1);
        ticks(1);
        chk("max_snz_timeout", ringing, 0);
        chk("max_snz_armed", armed, 1);

        // btn_arm beats btn_snooze
        minute = 6'd31; cyc(0, 0, 0, 0, 0);
        minute = 6'd30; cyc(0, 0, 0, 0, 0);
        chk("ring_again", ringing, 1);
        cyc(0, 0, 1, 1, 0);
        chk("arm_snz_ring", ringing, 0);
        chk("arm_snz_armed", armed, 0);
        chk("arm_snz_snoozing", snoozing, 0);

        // Arming inside the matching minute triggers; btn_set then ignored
        cyc(0, 0, 1, 0, 0);
        chk("late_arm_armed", armed, 1);
        chk("late_arm_no_ring_yet", ringing, 0);
        cyc(1, 0, 0, 0, 0);
        chk("late_arm_ring", ringing, 1);
        chk("late_arm_set_ignored", set_mode, 0);

        // Asynchronous reset during snooze
        cyc(0, 0, 0, 1, 0);
        chk("pre_rst_snoozing", snoozing, 1);
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_snoozing", snoozing, 0);
        chk("arst_ringing", ringing, 0);
        chk("arst_armed", armed, 0);
        chk("arst_hour", alarm_hour, 0);
        chk("arst_min", alarm_min, 0);
        chk("arst_mode", set_mode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cyc(0, 0, 0, 0, 0);
        chk("post_rst_no_ring", ringing, 0);
        cyc(0, 0, 1, 0, 0);
        chk("post_rst_armed", armed, 1);
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_no_match", ringing, 0);
        hour = 5'd0; minute = 6'd0;
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_match_0000", ringing, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller for the clock core.
- Sequences setting the alarm time (hour, then minute) from debounced buttons, and holds the arm/disarm state.
- Detects the alarm match against the running time, then runs the ring / snooze / auto-timeout sequence.
- Sits between the button front-end and the buzzer/display; consumes the time counters and the 1 Hz tick.

Parameters:
- SNOOZE_MIN, 5, snooze length in minutes (1..9).
- RING_TIMEOUT_S, 60, seconds of continuous ringing before automatic stop (>=1).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (>=0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- tick_1hz  in  1  single-cycle pulse once per second
- hour  in  5  current hour, 0..23
- minute  in  6  current minute, 0..59
- btn_set  in  1  single-cycle pulse: enter/advance set mode
- btn_up  in  1  single-cycle pulse: increment the selected field
- btn_arm  in  1  single-cycle pulse: toggle armed / stop alarm
- btn_snooze  in  1  single-cycle pulse: snooze the ringing alarm
- alarm_hour  out  5  stored alarm hour
- alarm_min  out  6  stored alarm minute
- armed  out  1  alarm enabled
- ringing  out  1  buzzer drive
- snoozing  out  1  snooze countdown active
- set_mode  out  2  0 = none, 1 = setting hour, 2 = setting minute

Behaviour:
- Reset: all outputs 0; FSM = IDLE; all counters 0; match_q = 0.
- Outputs are registered; each state change is visible the cycle after the causing input.
- match = armed && hour==alarm_hour && minute==alarm_min. match_q registers match every cycle, in every state.
- Trigger = match && !match_q. Arming during the matching minute therefore triggers. One trigger per minute match.
- IDLE (set_mode=0, ringing=0, snoozing=0):
  - Trigger -> RING; clear snooze_cnt and ring_sec. Trigger wins over btn_set in the same cycle.
  - btn_set -> SET_H.
  - btn_arm toggles armed.
- SET_H (set_mode=1):
  - btn_up: alarm_hour+1, wrapping 23->0.
  - btn_set -> SET_M.
  - btn_arm toggles armed.
  - Triggers are ignored (match_q still tracks).
- SET_M (set_mode=2):
  - btn_up: alarm_min+1, wrapping 59->0.
  - btn_set -> IDLE.
  - btn_arm toggles armed.
  - Triggers are ignored.
  - btn_up and btn_set in the same cycle: apply the increment, then change state.
- RING (ringing=1):
  - ring_sec increments on tick_1hz.
  - Priority: btn_arm > btn_snooze > timeout.
  - btn_arm: armed<=0 -> IDLE.
  - btn_snooze with snooze_cnt<MAX_SNOOZE: snooze_cnt+1, load snooze_sec=SNOOZE_MIN*60 -> SNOOZE.
  - btn_snooze with snooze_cnt==MAX_SNOOZE: ignored.
  - Timeout: tick while ring_sec==RING_TIMEOUT_S-1 -> IDLE with armed kept. Ringing therefore lasts exactly RING_TIMEOUT_S ticks.
  - btn_set and btn_up are ignored.
- SNOOZE (snoozing=1):
  - snooze_sec decrements on tick_1hz.
  - Tick while snooze_sec==1 -> RING; clear ring_sec, keep snooze_cnt.
  - btn_arm: armed<=0 -> IDLE. btn_snooze, btn_set and btn_up are ignored.
- Time and settings changes do not affect RING or SNOOZE once entered.
- Counter widths:
  - ring_sec: $clog2(RING_TIMEOUT_S+1)
  - snooze_sec: $clog2(SNOOZE_MIN*60+1)
  - snooze_cnt: $clog2(MAX_SNOOZE+1), minimum 1 bit
- Reset asserted mid-ring or mid-snooze: immediate return to the reset values above. Stored alarm time is lost.

Decomposition:
- Shared package clock_pkg:
  - FSM state enum: IDLE, SET_H, SET_M, RING, SNOOZE.
  - Constants: HOUR_MAX=23, MIN_MAX=59, SEC_PER_MIN=60, set_mode encodings.
- One sub-module, wrap_inc: parameterised modulo incrementer (WIDTH, MAX) with enable, used for both alarm_hour and alarm_min.

Test Plan:
Run with SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2, tick every 10 cycles.
- Set sequence: btn_set, 7x btn_up, btn_set, 30x btn_up, btn_set -> alarm_hour=7, alarm_min=30, set_mode returns 0. Then 17 more hour presses from 7 wrap to 0.
- Armed, time steps to 07:30 -> ringing=1 one cycle after the match. After 5 ticks with no buttons -> ringing=0, armed=1. No retrigger while minute stays 30.
- Ringing, btn_snooze -> snoozing=1. After 60 ticks -> ringing=1. Snooze twice more -> third press ignored, ringing stays 1.
- btn_arm and btn_snooze in the same cycle while ringing -> IDLE, armed=0, snoozing=0.
- Time already 07:30, disarmed; btn_arm -> ringing=1 next cycle. btn_set in the trigger cycle is ignored, set_mode stays 0.
- rst_n low during SNOOZE -> all outputs 0 asynchronously. After release: no ring until the next armed match.
